// File: rtl/mem_pkg.sv
// Shared widths and FSM state type for the L1 refill engine.
package mem_pkg;

  localparam int unsigned WORD_W          = 32;
  localparam int unsigned BLOCK_W         = 128;
  localparam int unsigned ADDR_W          = 30;
  localparam int unsigned WORDS_PER_BLOCK = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StFetch,
    StDeliver
  } state_t;

endpackage

// File: rtl/mem_word_ram.sv
// Single-port word RAM: synchronous read, write-first (a write returns the new word).
module mem_word_ram
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Storage is deliberately not reset so preloaded contents survive rst.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_refill.sv
// Fixed-latency block refill: wait LATENCY cycles, fetch four words, present them for one cycle.
module mem_refill
  import mem_pkg::*;
#(
  parameter int unsigned LATENCY     = 4,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic [ADDR_W-1:0]  req_addr,
  output logic               delivered,
  output logic [BLOCK_W-1:0] blockin,
  output logic               busy,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [WORD_W-1:0]  load_data
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [1:0]          widx_q, widx_d;
  logic [ADDR_W-3:0]   base_q, base_d;
  logic [BLOCK_W-1:0]  asm_q, asm_d;
  logic [BLOCK_W-1:0]  blockin_q, blockin_d;

  logic                ram_we;
  logic [AW-1:0]       ram_addr;
  logic [WORD_W-1:0]   ram_rdata;
  logic [1:0]          rd_idx;
  logic [ADDR_W-1:0]   fetch_addr;
  logic                unused_bits;

  // The read for word 0 is issued in the last WAIT cycle so each FETCH cycle sees its word
  // on rdata; afterwards each FETCH cycle pre-issues the next word.
  always_comb begin
    rd_idx     = (state_q == StWait) ? 2'd0 : widx_q + 2'd1;
    fetch_addr = {base_q, rd_idx};
    ram_we     = (state_q == StIdle) && load_en;
    ram_addr   = (state_q == StIdle) ? load_addr[AW-1:0] : fetch_addr[AW-1:0];
  end

  assign unused_bits = ^{req_addr[1:0], load_addr[ADDR_W-1:AW], fetch_addr[ADDR_W-1:AW]};

  mem_word_ram #(
    .DEPTH (DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (load_data),
    .rdata (ram_rdata)
  );

  // Next-state logic: accept, count down the wait, assemble words, publish block.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    widx_d    = widx_q;
    base_d    = base_q;
    asm_d     = asm_q;
    blockin_d = blockin_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          base_d  = req_addr[ADDR_W-1:2];
          cnt_d   = 8'(LATENCY);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 8'd1) begin
          cnt_d   = 8'd0;
          widx_d  = 2'd0;
          state_d = StFetch;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StFetch: begin
        asm_d[{widx_q, 5'b0} +: WORD_W] = ram_rdata;
        widx_d = widx_q + 2'd1;
        if (widx_q == 2'(WORDS_PER_BLOCK - 1)) begin
          blockin_d = {ram_rdata, asm_q[3*WORD_W-1:0]};
          state_d   = StDeliver;
        end
      end
      StDeliver: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with asynchronous clear; a reset mid-refill simply drops the refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 8'd0;
      widx_q    <= 2'd0;
      base_q    <= '0;
      asm_q     <= '0;
      blockin_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      widx_q    <= widx_d;
      base_q    <= base_d;
      asm_q     <= asm_d;
      blockin_q <= blockin_d;
    end
  end

  assign delivered = (state_q == StDeliver);
  assign busy      = (state_q != StIdle);
  assign blockin   = blockin_q;

endmodule

// File: tb/tb_mem_refill.sv
// Randomized bench for mem_refill against an array model of the backing store.
module tb_mem_refill;

  localparam int unsigned LAT   = 4;
  localparam int unsigned DEPTH = 1024;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req = 1'b0;
  logic [29:0]  req_addr = '0;
  logic         load_en = 1'b0;
  logic [29:0]  load_addr = '0;
  logic [31:0]  load_data = '0;
  logic         delivered;
  logic         busy;
  logic [127:0] blockin;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [DEPTH];

  mem_refill #(
    .LATENCY     (LAT),
    .DEPTH_WORDS (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_addr  (req_addr),
    .delivered (delivered),
    .blockin   (blockin),
    .busy      (busy),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  always #5 clk = ~clk;

  // Expected block: words (addr/4)*4 + k modulo the store size, word k in slot k.
  function automatic logic [127:0] model_block(input logic [29:0] a);
    logic [127:0] b;
    int unsigned  w;
    b = '0;
    for (int k = 0; k < 4; k++) begin
      w = ((32'(a) >> 2) * 4 + 32'(k)) % DEPTH;
      b[32*k +: 32] = model_mem[10'(w)];
    end
    return b;
  endfunction

  // Write one word while idle; starts and ends just after a falling edge.
  task automatic do_load(input logic [29:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    model_mem[10'(a % DEPTH)] = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // mode 0: plain; 1: stray load during WAIT (must be dropped); 2: load on the accept edge.
  task automatic run_refill(input logic [29:0] a, input int mode, input logic [29:0] la,
                            input logic [31:0] ld, input bit hold);
    int           c;
    bit           done;
    logic [127:0] exp;
    req      = 1'b1;
    req_addr = a;
    if (mode == 2) begin
      load_en   = 1'b1;
      load_addr = la;
      load_data = ld;
      model_mem[10'(la % DEPTH)] = ld;
    end
    @(negedge clk);
    load_en = 1'b0;
    exp     = model_block(a);
    if (mode == 1) begin
      load_en   = 1'b1;
      load_addr = la;
      load_data = ld;
    end
    c    = 0;
    done = 1'b0;
    while (!done && c <= int'(LAT) + 20) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_in_refill cycle %0d: got %b want 1", c, busy);
      end
      if (delivered === 1'b1) begin
        done = 1'b1;
      end else begin
        @(negedge clk);
        load_en = 1'b0;
        c++;
      end
    end
    load_en = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL deliver_timeout addr %h: no delivered within %0d cycles", a, c);
    end else if (c != int'(LAT) + 4) begin
      errors++;
      $display("FAIL latency addr %h: got %0d want %0d", a, c, LAT + 4);
    end
    checks++;
    if (blockin !== exp) begin
      errors++;
      $display("FAIL blockin addr %h: got %h want %h", a, blockin, exp);
    end
    req = hold;
    @(negedge clk);
    checks++;
    if (delivered !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_deliver addr %h: delivered %b busy %b want 0 0", a, delivered, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || delivered !== 1'b0 || blockin !== 128'h0) begin
      errors++;
      $display("FAIL reset_state: busy %b delivered %b blockin %h want 0 0 0",
               busy, delivered, blockin);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_preload();
    for (int i = 0; i < int'(DEPTH); i++) do_load(30'(i), $urandom);
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) do_load(30'(32'h40 + i), 32'hA0 + 32'(i));
    run_refill(30'h41, 0, 30'h0, 32'h0, 1'b0);
    checks++;
    if (blockin !== 128'h000000A3_000000A2_000000A1_000000A0) begin
      errors++;
      $display("FAIL basic_block_held: got %h want 000000a3000000a2000000a1000000a0", blockin);
    end
  endtask

  task automatic test_hold();
    run_refill(30'h41, 0, 30'h0, 32'h0, 1'b1);
    run_refill(30'h2A5, 0, 30'h0, 32'h0, 1'b0);
  endtask

  task automatic test_load_in_wait();
    run_refill(30'h40, 1, 30'h41, 32'hFF, 1'b0);
    checks++;
    if (blockin[63:32] !== 32'hA1) begin
      errors++;
      $display("FAIL wait_load_inflight: slot1 got %h want 000000a1", blockin[63:32]);
    end
    run_refill(30'h43, 0, 30'h0, 32'h0, 1'b0);
    checks++;
    if (blockin[63:32] !== 32'hA1) begin
      errors++;
      $display("FAIL wait_load_later: slot1 got %h want 000000a1", blockin[63:32]);
    end
  endtask

  task automatic test_reset_mid();
    bit pulse;
    req      = 1'b1;
    req_addr = 30'h123;
    @(negedge clk);
    repeat (LAT + 1) @(negedge clk);
    req = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || delivered !== 1'b0 || blockin !== 128'h0) begin
      errors++;
      $display("FAIL reset_mid_refill: busy %b delivered %b blockin %h want 0 0 0",
               busy, delivered, blockin);
    end
    @(negedge clk);
    rst   = 1'b0;
    pulse = 1'b0;
    repeat (LAT + 8) begin
      @(negedge clk);
      if (delivered === 1'b1 || busy === 1'b1) pulse = 1'b1;
    end
    checks++;
    if (pulse) begin
      errors++;
      $display("FAIL reset_abort: got activity after reset want none");
    end
    run_refill(30'h41, 0, 30'h0, 32'h0, 1'b0);
  endtask

  task automatic test_wrap();
    logic [127:0] exp;
    run_refill(30'h3FF, 0, 30'h0, 32'h0, 1'b0);
    exp = {model_mem[10'h3FF], model_mem[10'h3FE], model_mem[10'h3FD], model_mem[10'h3FC]};
    checks++;
    if (blockin !== exp) begin
      errors++;
      $display("FAIL wrap_top: got %h want %h", blockin, exp);
    end
    run_refill(30'h400, 0, 30'h0, 32'h0, 1'b0);
    exp = {model_mem[10'h3], model_mem[10'h2], model_mem[10'h1], model_mem[10'h0]};
    checks++;
    if (blockin !== exp) begin
      errors++;
      $display("FAIL wrap_zero: got %h want %h", blockin, exp);
    end
  endtask

  task automatic test_same_edge();
    run_refill(30'h80, 2, 30'h80, 32'h55, 1'b0);
    checks++;
    if (blockin[31:0] !== 32'h55) begin
      errors++;
      $display("FAIL same_edge_load: slot0 got %h want 00000055", blockin[31:0]);
    end
  endtask

  task automatic test_random();
    bit prev_hold;
    bit hold;
    prev_hold = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (!prev_hold && $urandom_range(0, 2) == 0) do_load(30'($urandom), $urandom);
      hold = (i != 23) && ($urandom_range(0, 1) == 1);
      run_refill(30'($urandom), int'($urandom_range(0, 2)), 30'($urandom), $urandom, hold);
      prev_hold = hold;
    end
    req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_preload();
    test_basic();
    test_hold();
    test_load_in_wait();
    test_reset_mid();
    test_wrap();
    test_same_edge();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_refill.md
MEM_REFILL -- requirements
Module: mem_refill

Interface
REQ-001 Parameter LATENCY, default 4: wait cycles between request acceptance and the first word fetch; legal range 1..255.
REQ-002 Parameter DEPTH_WORDS, default 1024: backing store size in 32-bit words; power of two, at least 4.
REQ-003 Port clk  input  1  sole clock; all state is updated on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port req  input  1  miss request from L1; level, held by requester until delivered.
REQ-006 Port req_addr  input  30  word address (25b tag, 3b index, 2b word offset); bits [1:0] ignored.
REQ-007 Port delivered  output  1  one-cycle pulse; blockin is valid while it is high.
REQ-008 Port blockin  output  128  refill block; word w at bits [32*w+31 : 32*w].
REQ-009 Port busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 Port load_en  input  1  backing-store write strobe (preload/store path).
REQ-011 Port load_addr  input  30  word address for load; taken modulo DEPTH_WORDS.
REQ-012 Port load_data  input  32  word to write.

Function
REQ-013 FSM states SHALL be IDLE, WAIT, FETCH, DELIVER.
REQ-014 In IDLE with req=1, the block SHALL latch req_addr[29:2] as the block base at the rising edge and enter WAIT.
REQ-015 WAIT SHALL last exactly LATENCY cycles, counted by an 8-bit down-counter, then enter FETCH.
REQ-016 FETCH SHALL read words base*4+0..3 (modulo DEPTH_WORDS), one per cycle, in ascending order, packing each into its blockin slot.
REQ-017 DELIVER SHALL last one cycle with delivered=1, then return to IDLE.
REQ-018 delivered SHALL first be high exactly LATENCY+4 cycles after the acceptance edge; end-to-end latency is fixed.
REQ-019 blockin SHALL hold its last value outside DELIVER and be 0 after reset.
REQ-020 req SHALL be ignored outside IDLE; no request queueing.
REQ-021 req still high in the cycle after DELIVER SHALL be treated as a new request.
REQ-022 load_en in IDLE SHALL write load_data at the next edge.
REQ-023 load_en outside IDLE SHALL be ignored; no write occurs, so an in-flight refill always returns pre-request data.
REQ-024 Simultaneous req and load_en in IDLE: the write SHALL commit and the request is accepted in the same edge; the fetch SHALL observe the written word.
REQ-025 Address arithmetic SHALL be unsigned; block word addresses wrap at DEPTH_WORDS.

Reset
REQ-026 On rst assertion, without waiting for a clock edge: state=IDLE, delivered=0, busy=0, blockin=0, counters=0.
REQ-027 Reset mid-refill SHALL abort the refill with no delivered pulse.
REQ-028 Backing store contents SHALL NOT be cleared by reset.

Structure
REQ-029 Shared package mem_pkg SHALL hold WORD_W=32, BLOCK_W=128, ADDR_W=30, WORDS_PER_BLOCK=4 and the FSM state enum.
REQ-030 The backing store SHALL be one sub-module, mem_word_ram: single-port, synchronous read, write-first; the FSM accounts for its one-cycle read latency.

Verification
REQ-031 Preload words 0x40..0x43 with 0xA0..0xA3; LATENCY=4; req_addr=0x41 -> delivered exactly 8 cycles after acceptance, blockin=0x000000A3_000000A2_000000A1_000000A0.
REQ-032 Hold req through delivered -> exactly one delivered pulse, then a second refill accepted the next cycle; busy high throughout each refill.
REQ-033 Assert load_en to 0x41 with 0xFF during WAIT -> store unchanged; a later refill still returns 0xA1 in slot 1.
REQ-034 Assert rst in FETCH cycle 2 -> busy=0 and blockin=0 immediately; no delivered pulse; the next req completes normally.
REQ-035 DEPTH_WORDS=1024, req_addr=0x3FF -> words 0x3FC..0x3FF fetched; req_addr=0x400 -> words 0..3 fetched (wrap).
REQ-036 Same-edge load_en (addr 0x80, 0x55) and req (addr 0x80) in IDLE -> blockin[31:0]=0x55.
